// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundle of the read, write and scoreboard signals of the register file.
//
// master: decode/writeback side; drives addresses, write data and scoreboard strobes.
// slave : the register file; drives read data, read busy flags and any_busy.
//
// Signals:
//   re       read enable; rd/rbusy hold when low
//   rr       packed read addresses, port i at rr[i*AW +: AW]
//   rd       packed registered read data, port i at rd[i*XLEN +: XLEN]
//   rbusy    registered busy flag of each read address
//   we/wr/wd write enable, address, data
//   iss      issue strobe, marks iss_rd busy
//   iss_rd   destination register being issued
//   flush    synchronous clear of every busy bit
//   any_busy OR of all busy bits
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic                 re;
  logic [NRP*AW-1:0]    rr;
  logic [NRP*XLEN-1:0]  rd;
  logic [NRP-1:0]       rbusy;
  logic                 we;
  logic [AW-1:0]        wr;
  logic [XLEN-1:0]      wd;
  logic                 iss;
  logic [AW-1:0]        iss_rd;
  logic                 flush;
  logic                 any_busy;

  modport master (
    output re, rr, we, wr, wd, iss, iss_rd, flush,
    input  rd, rbusy, any_busy
  );

  modport slave (
    input  re, rr, we, wr, wd, iss, iss_rd, flush,
    output rd, rbusy, any_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with a busy scoreboard.
//
// x0 is hardwired to zero and is never busy. Each read port registers the addressed data and
// busy bit on a rising edge with re=1 (one cycle latency). Writeback writes data and clears
// the busy bit; issue sets it; flush clears every busy bit with top priority.
//
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-low reset
//   bus  regfile_mp_if.slave (see the interface file for the individual signals)
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of the register written in the same cycle
//                      captures the write data and the post-update busy bit. When undefined,
//                      reads see the pre-write value and pre-update busy bit.
module regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  // Architectural state
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;

  // Registered read ports
  logic [NRP-1:0][XLEN-1:0]  rd_q, rd_d;
  logic [NRP-1:0]            rbusy_q, rbusy_d;

  logic [NRP-1:0][AW-1:0]    raddr;
  logic                      wr_hit;

  assign raddr  = bus.rr;
  // Writes to x0 are dropped everywhere, so qualify the enable once.
  assign wr_hit = bus.we && (bus.wr != '0);

  // Register array next state
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[bus.wr] = bus.wd;
    end
    regs_d[0] = '0;
  end

  // Scoreboard next state: flush > issue set > writeback clear > hold
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (bus.flush) begin
        busy_d[r] = 1'b0;
      end else if (bus.iss && (bus.iss_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (bus.we && (bus.wr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Read port next state
  always_comb begin
    rd_d    = rd_q;
    rbusy_d = rbusy_q;
    if (bus.re) begin
      for (int unsigned i = 0; i < NRP; i++) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (raddr[i] == bus.wr)) begin
          rd_d[i]    = bus.wd;
          rbusy_d[i] = busy_d[raddr[i]];
        end else begin
          rd_d[i]    = regs_q[raddr[i]];
          rbusy_d[i] = busy_q[raddr[i]];
        end
`else
        rd_d[i]    = regs_q[raddr[i]];
        rbusy_d[i] = busy_q[raddr[i]];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q  <= '0;
      busy_q  <= '0;
      rd_q    <= '0;
      rbusy_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign bus.rd       = rd_q;
  assign bus.rbusy    = rbusy_q;
  assign bus.any_busy = |busy_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the tiny RISC-V core. It is the next generation of the single-width, 2-read, 32x32 register file.
- Adds configurable width, depth and read-port count, and hardwires x0 to zero.
- Adds a per-register busy scoreboard so decode can detect RAW hazards on in-flight writes.
- Sits between decode (reads, issue/busy set) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; must be a power of 2, >= 2.
- NRP, 2, number of read ports.
- AW, $clog2(NREG), register address width (derived; do not override).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- re, input, 1, read enable; when 0, rd and rbusy hold their previous values.
- rr, input, NRP*AW, packed read addresses; port i uses rr[i*AW +: AW].
- rd, output, NRP*XLEN, packed registered read data; port i uses rd[i*XLEN +: XLEN].
- rbusy, output, NRP, registered busy flag of each read address.
- we, input, 1, write enable.
- wr, input, AW, write address.
- wd, input, XLEN, write data.
- iss, input, 1, issue strobe; marks register iss_rd busy.
- iss_rd, input, AW, destination register being issued.
- flush, input, 1, synchronous clear of all busy bits.
- any_busy, output, 1, combinational OR of all busy bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers are 0, all busy bits are 0.
  - rd = 0, rbusy = 0, any_busy = 0.
  - Reset asserted mid-operation discards pending writes and issues immediately.
- Read:
  - Latency is 1 cycle. On a rising edge with re=1, port i samples reg[rr_i] and busy[rr_i] into rd_i and rbusy_i.
  - All NRP ports are independent. Any number of ports may address the same register.
  - re=0 holds rd and rbusy unchanged.
- Write:
  - On a rising edge with we=1 and wr != 0, reg[wr] <= wd.
  - A write to x0 is ignored; reg[0] always reads 0 and busy[0] always reads 0.
- Scoreboard, evaluated per register r != 0 each edge:
  - flush=1: busy[r] <= 0. Flush has priority over both iss and we.
  - Else iss=1 and iss_rd=r: busy[r] <= 1. Set wins over a same-cycle clear, because a new producer is issued.
  - Else we=1 and wr=r: busy[r] <= 0.
  - Otherwise busy[r] holds.
  - An issue to x0 is ignored.
- Same-cycle read/write of the same register, without bypass:
  - rd returns the pre-write value.
  - rbusy returns the pre-update busy bit.
- Write and issue to different registers in the same cycle are fully independent.
- Busy bits are flops; rbusy adds one more cycle of registered latency on top of them.

Optional Feature:
- Macro name: REGFILE_BYPASS_EN.
- Defined:
  - When re=1, we=1, wr != 0 and rr_i == wr, port i captures wd instead of the stored value (write-through).
  - rbusy_i captures the post-update busy value: 0 if only the write hits, 1 if iss also hits the same register.
- Undefined:
  - Read-before-write as above.
  - No combinational path from wd to the rd registers.

Test Plan:
- Reset then read: release rst; re=1 with rr0=5, rr1=31 -> next cycle rd0=0, rd1=0, rbusy=0, any_busy=0.
- Write/read all: write reg[k] = 32'hA5A5_0000+k for k=1..31, then read pairs (k, 32-k) -> rd0 = A5A5_0000+k and rd1 = A5A5_0000+(32-k). Write 32'hDEADBEEF to x0, then read x0 -> 0.
- Same-address collision: reg[7]=32'h11; same cycle we=1, wr=7, wd=32'h22, rr0=7 -> rd0=32'h11 without the macro and 32'h22 with REGFILE_BYPASS_EN. The next read of 7 returns 32'h22 in both builds.
- Scoreboard sequence:
  - iss to register 3 -> any_busy=1; a read of 3 gives rbusy0=1.
  - we to register 3 -> busy cleared; a read of 3 gives rbusy0=0.
  - iss and we both to register 9 in the same cycle -> busy[9]=1.
- Flush priority: set busy on registers 4 and 6; then in one cycle flush=1 with iss_rd=4 -> all busy bits 0 and any_busy=0. An iss to x0 never raises any_busy.
- Reset mid-run: with busy[5]=1 and reg[5]=32'h55, assert rst asynchronously between edges -> rd, rbusy and any_busy go to 0 immediately. After release, a read of 5 returns 0.
